// File: rtl/triangle_span_walker_pkg.sv
// render_pkg: shared widths, types and fixed-point helpers for the triangle
// span walker and its slope divider.
//   COORD_W / FRAC_W : coordinate width and slope/accumulator fraction bits
//   vertex_t         : {x, y} signed vertex
//   span_t           : {y, xl, xr, last} emitted span
//   walker_state_e   : walker FSM states
package render_pkg;

    localparam int COORD_W = 16;
    localparam int FRAC_W  = 16;
    localparam int QUOT_W  = COORD_W + 1 + FRAC_W;   // |dx| << FRAC_W
    localparam int DIVR_W  = COORD_W;                // dy is never negative
    localparam int ACC_W   = COORD_W + FRAC_W + 2;

    typedef logic signed [COORD_W-1:0] coord_t;
    typedef logic signed [COORD_W:0]   delta_t;
    typedef logic signed [ACC_W-1:0]   acc_t;

    typedef struct packed {
        coord_t x;
        coord_t y;
    } vertex_t;

    typedef struct packed {
        coord_t y;
        coord_t xl;
        coord_t xr;
        logic   last;
    } span_t;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        DIV_L,
        DIV_A,
        DIV_B,
        SPAN
    } walker_state_e;

    localparam logic [ACC_W-1:0] ACC_HALF = ACC_W'(1) << (FRAC_W - 1);

    // Signed difference b - a, one bit wider so it never overflows.
    function automatic delta_t delta(input coord_t a, input coord_t b);
        return {b[COORD_W-1], b} - {a[COORD_W-1], a};
    endfunction

    // Fixed-point x plus one half, so truncating the fraction rounds half-up.
    function automatic acc_t fx_init(input coord_t x);
        acc_t a;
        a = {{(ACC_W-COORD_W-FRAC_W){x[COORD_W-1]}}, x, {FRAC_W{1'b0}}};
        return a + acc_t'(ACC_HALF);
    endfunction

    function automatic coord_t min2(input coord_t a, input coord_t b);
        return (a < b) ? a : b;
    endfunction

    function automatic coord_t max2(input coord_t a, input coord_t b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/triangle_span_walker_if.sv
// Triangle-in / span-out bundle of the span walker.
//   in_valid/in_ready + v1..v3 : sorted triangle from the y-sort stage
//   span_valid/span_ready + span_y/xl/xr/last : spans to pixel fill
//   busy : walker is not idle
// master = upstream/downstream side, slave = the walker.
interface triangle_span_walker_if;
    import render_pkg::*;

    logic   in_valid;
    logic   in_ready;
    coord_t v1x, v1y, v2x, v2y, v3x, v3y;
    logic   span_valid;
    logic   span_ready;
    coord_t span_y, span_xl, span_xr;
    logic   span_last;
    logic   busy;

    modport master (
        output in_valid, v1x, v1y, v2x, v2y, v3x, v3y, span_ready,
        input  in_ready, span_valid, span_y, span_xl, span_xr, span_last, busy
    );

    modport slave (
        input  in_valid, v1x, v1y, v2x, v2y, v3x, v3y, span_ready,
        output in_ready, span_valid, span_y, span_xl, span_xr, span_last, busy
    );

endinterface

// File: rtl/triangle_span_walker_slope_divider.sv
// slope_divider: unsigned restoring radix-2 serial divider, one quotient bit
// per cycle, QUOT_W cycles per division.
//   clk, rst  : clock, async active-high reset
//   start     : load operands; the first bit is resolved in the same cycle
//   dividend  : QUOT_W-bit unsigned numerator
//   divisor   : DIVR_W-bit unsigned denominator, must be nonzero
//   done      : one-cycle pulse while quotient holds the final result
//   quotient  : QUOT_W-bit unsigned result, remainder discarded
module slope_divider
    import render_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [QUOT_W-1:0] dividend,
    input  logic [DIVR_W-1:0] divisor,
    output logic              done,
    output logic [QUOT_W-1:0] quotient
);

    logic [DIVR_W-1:0] rem_q;
    logic [DIVR_W-1:0] divisor_q;
    logic [QUOT_W-1:0] quot_q;
    logic [5:0]        bits_left;

    logic [DIVR_W-1:0] dvs;
    logic [DIVR_W:0]   trial;
    logic              fits;
    logic [DIVR_W-1:0] rem_next;

    // quot_q shifts dividend bits out the top and quotient bits in the bottom.
    always_comb begin
        dvs      = start ? divisor : divisor_q;
        trial    = start ? {{DIVR_W{1'b0}}, dividend[QUOT_W-1]}
                         : {rem_q, quot_q[QUOT_W-1]};
        fits     = (trial >= {1'b0, dvs});
        rem_next = fits ? DIVR_W'(trial - {1'b0, dvs}) : trial[DIVR_W-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_q     <= '0;
            divisor_q <= '0;
            quot_q    <= '0;
            bits_left <= '0;
            done      <= 1'b0;
        end else if (start) begin
            divisor_q <= divisor;
            rem_q     <= rem_next;
            quot_q    <= {dividend[QUOT_W-2:0], fits};
            bits_left <= 6'(QUOT_W - 1);
            done      <= 1'b0;
        end else if (bits_left != '0) begin
            rem_q     <= rem_next;
            quot_q    <= {quot_q[QUOT_W-2:0], fits};
            bits_left <= bits_left - 6'd1;
            done      <= (bits_left == 6'd1);
        end else begin
            done      <= 1'b0;
        end
    end

    assign quotient = quot_q;

endmodule

// File: rtl/triangle_span_walker.sv
// triangle_span_walker: takes one y-sorted triangle, derives the long edge
// (v1->v3) and short edge (v1->v2, then v2->v3) slopes with a serial divider,
// then emits one span (y, xl, xr, last) per scanline v1y..v3y.
//   clk, rst : clock, async active-high reset
//   bus      : slave side of triangle_span_walker_if
//
//   state | meaning
//   IDLE  | waiting for a triangle, in_ready high
//   SETUP | vertices latched, long-edge division launched
//   DIV_L | long-edge slope division (1 cycle if flat)
//   DIV_A | upper short-edge slope division
//   DIV_B | lower short-edge slope division
//   SPAN  | emitting spans under span_ready backpressure
module triangle_span_walker
    import render_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    triangle_span_walker_if.slave bus
);

    walker_state_e state_q, state_d;

    vertex_t v1_q, v2_q, v3_q;
    acc_t    slope_l_q, slope_a_q, slope_b_q;
    acc_t    acc_l_q, acc_s_q;
    logic    use_b_q;
    logic    valid_q;
    span_t   span_q;

    delta_t            dx_l, dy_l, dx_a, dy_a, dx_b, dy_b;
    logic              phase_done, div_start, div_done;
    logic              cur_neg, cur_flat;
    delta_t            div_dx, div_mag;
    coord_t            div_dy;
    logic [QUOT_W-1:0] div_quot;
    acc_t              quot_ext, slope_new;

    logic   span_fire, flat_top, flat_tri, reload;
    coord_t xs0, y_n, xl_n, xs_n;
    acc_t   acc_l_n, acc_s_n;
    span_t  first_span, next_span;

    assign dx_l = delta(v1_q.x, v3_q.x);
    assign dy_l = delta(v1_q.y, v3_q.y);
    assign dx_a = delta(v1_q.x, v2_q.x);
    assign dy_a = delta(v1_q.y, v2_q.y);
    assign dx_b = delta(v2_q.x, v3_q.x);
    assign dy_b = delta(v2_q.y, v3_q.y);

    // Each DIV state launches the next division on its final cycle, so the
    // divider's done pulse lines up with the last cycle of the owning state.
    always_comb begin
        phase_done = 1'b0;
        div_start  = 1'b0;
        div_dx     = '0;
        div_dy     = '0;
        cur_neg    = 1'b0;
        cur_flat   = 1'b1;
        case (state_q)
            SETUP: begin
                div_start = (dy_l != '0);
                div_dx    = dx_l;
                div_dy    = dy_l[COORD_W-1:0];
            end
            DIV_L: begin
                cur_neg    = dx_l[COORD_W];
                cur_flat   = (dy_l == '0);
                phase_done = cur_flat || div_done;
                div_start  = phase_done && (dy_a != '0);
                div_dx     = dx_a;
                div_dy     = dy_a[COORD_W-1:0];
            end
            DIV_A: begin
                cur_neg    = dx_a[COORD_W];
                cur_flat   = (dy_a == '0);
                phase_done = cur_flat || div_done;
                div_start  = phase_done && (dy_b != '0);
                div_dx     = dx_b;
                div_dy     = dy_b[COORD_W-1:0];
            end
            DIV_B: begin
                cur_neg    = dx_b[COORD_W];
                cur_flat   = (dy_b == '0);
                phase_done = cur_flat || div_done;
            end
            default: ;
        endcase
    end

    assign div_mag   = div_dx[COORD_W] ? -div_dx : div_dx;
    assign quot_ext  = acc_t'({1'b0, div_quot});
    assign slope_new = cur_flat ? '0 : (cur_neg ? -quot_ext : quot_ext);

    slope_divider u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start),
        .dividend ({div_mag, {FRAC_W{1'b0}}}),
        .divisor  (div_dy),
        .done     (div_done),
        .quotient (div_quot)
    );

    assign span_fire = valid_q && bus.span_ready;
    assign flat_top  = (v1_q.y == v2_q.y);
    assign flat_tri  = (v1_q.y == v3_q.y);

    always_comb begin
        xs0            = flat_top ? v2_q.x : v1_q.x;
        first_span.y    = v1_q.y;
        first_span.last = flat_tri;
        if (flat_tri) begin
            first_span.xl = min2(v1_q.x, min2(v2_q.x, v3_q.x));
            first_span.xr = max2(v1_q.x, max2(v2_q.x, v3_q.x));
        end else begin
            first_span.xl = min2(v1_q.x, xs0);
            first_span.xr = max2(v1_q.x, xs0);
        end

        // Crossing v2y reloads the short edge from v2 instead of
        // accumulating, which avoids carrying edge-A rounding into edge B.
        y_n     = span_q.y + coord_t'(1);
        reload  = (y_n == v2_q.y);
        acc_l_n = acc_l_q + slope_l_q;
        acc_s_n = reload ? fx_init(v2_q.x)
                         : acc_s_q + (use_b_q ? slope_b_q : slope_a_q);
        xl_n    = acc_l_n[FRAC_W +: COORD_W];
        xs_n    = acc_s_n[FRAC_W +: COORD_W];

        next_span.y    = y_n;
        next_span.xl   = min2(xl_n, xs_n);
        next_span.xr   = max2(xl_n, xs_n);
        next_span.last = (y_n == v3_q.y);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.in_valid) state_d = SETUP;
            SETUP:   state_d = DIV_L;
            DIV_L:   if (phase_done) state_d = DIV_A;
            DIV_A:   if (phase_done) state_d = DIV_B;
            DIV_B:   if (phase_done) state_d = SPAN;
            SPAN:    if (span_fire && span_q.last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready   = (state_q == IDLE);
        bus.busy       = (state_q != IDLE);
        bus.span_valid = valid_q;
        bus.span_y     = span_q.y;
        bus.span_xl    = span_q.xl;
        bus.span_xr    = span_q.xr;
        bus.span_last  = span_q.last;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q      <= '0;
            v2_q      <= '0;
            v3_q      <= '0;
            slope_l_q <= '0;
            slope_a_q <= '0;
            slope_b_q <= '0;
            acc_l_q   <= '0;
            acc_s_q   <= '0;
            use_b_q   <= 1'b0;
            valid_q   <= 1'b0;
            span_q    <= '0;
        end else begin
            if (state_q == IDLE && bus.in_valid) begin
                v1_q <= '{x: bus.v1x, y: bus.v1y};
                v2_q <= '{x: bus.v2x, y: bus.v2y};
                v3_q <= '{x: bus.v3x, y: bus.v3y};
            end

            if (phase_done) begin
                case (state_q)
                    DIV_L:   slope_l_q <= slope_new;
                    DIV_A:   slope_a_q <= slope_new;
                    DIV_B:   slope_b_q <= slope_new;
                    default: ;
                endcase
            end

            if (state_q == DIV_B && phase_done) begin
                acc_l_q <= fx_init(v1_q.x);
                acc_s_q <= fx_init(xs0);
                use_b_q <= flat_top;
                valid_q <= 1'b1;
                span_q  <= first_span;
            end else if (span_fire) begin
                if (span_q.last) begin
                    valid_q <= 1'b0;
                end else begin
                    acc_l_q <= acc_l_n;
                    acc_s_q <= acc_s_n;
                    use_b_q <= use_b_q | reload;
                    span_q  <= next_span;
                end
            end
        end
    end

endmodule

// File: tb/tb_triangle_span_walker.sv
module tb_triangle_span_walker;
    import render_pkg::*;

    logic  clk = 1'b0;
    logic  rst = 1'b1;
    int    errors = 0;
    int    checks = 0;
    span_t sb[$];

    triangle_span_walker_if bus ();

    triangle_span_walker dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_span(input string tag, input span_t exp);
        span_t obs;
        obs = '{y: bus.span_y, xl: bus.span_xl, xr: bus.span_xr, last: bus.span_last};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed y=%0d xl=%0d xr=%0d last=%0b expected y=%0d xl=%0d xr=%0d last=%0b",
                   tag, obs.y, obs.xl, obs.xr, obs.last, exp.y, exp.xl, exp.xr, exp.last);
        end
    endtask

    task automatic push(input int y, input int xl, input int xr, input bit last);
        sb.push_back('{y: coord_t'(y), xl: coord_t'(xl), xr: coord_t'(xr), last: last});
    endtask

    task automatic set_verts(input int ax, input int ay, input int bx, input int by,
                             input int cx, input int cy);
        bus.v1x = coord_t'(ax); bus.v1y = coord_t'(ay);
        bus.v2x = coord_t'(bx); bus.v2y = coord_t'(by);
        bus.v3x = coord_t'(cx); bus.v3y = coord_t'(cy);
    endtask

    // Drive a triangle's vertices and queue its hand-derived spans.
    task automatic load_tri(input int id);
        case (id)
            0: begin
                set_verts(0, 5, 10, 5, 4, 5);
                push(5, 0, 10, 1);
            end
            1: begin
                set_verts(0, 0, 0, 4, 4, 4);
                push(0, 0, 0, 0); push(1, 0, 1, 0); push(2, 0, 2, 0);
                push(3, 0, 3, 0); push(4, 0, 4, 1);
            end
            default: begin
                set_verts(-8, -2, 6, 0, -2, 2);
                push(-2, -8, -8, 0); push(-1, -6, -1, 0); push(0, -5, 6, 0);
                push(1, -3, 2, 0);   push(2, -2, -2, 1);
            end
        endcase
    endtask

    task automatic accept(input string tag, input bit hold);
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        while (bus.in_ready !== 1'b1 && n < 400) begin
            tick();
            n++;
        end
        check({tag, "_in_ready"}, bus.in_ready, 1);
        tick();
        check({tag, "_busy"}, bus.busy, 1);
        if (!hold) bus.in_valid = 1'b0;
    endtask

    task automatic wait_valid(input string tag, input int exp_lat);
        int n;
        n = 0;
        while (bus.span_valid !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        check({tag, "_latency"}, n, exp_lat);
    endtask

    task automatic drain(input string tag, input int n, input int stall_at, input bit ends);
        span_t exp;
        int    w;
        for (int i = 0; i < n; i++) begin
            w = 0;
            while (bus.span_valid !== 1'b1 && w < 8) begin
                tick();
                w++;
            end
            if (i > 0) check({tag, "_gap"}, w, 0);
            check({tag, "_sb_nonempty"}, sb.size() > 0, 1);
            exp = '0;
            if (sb.size() > 0) exp = sb.pop_front();
            check_span({tag, "_span"}, exp);
            if (i == stall_at) begin
                bus.span_ready = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    tick();
                    check({tag, "_stall_valid"}, bus.span_valid, 1);
                    check_span({tag, "_stall_hold"}, exp);
                end
                bus.span_ready = 1'b1;
            end
            tick();
        end
        if (ends) begin
            check({tag, "_after_in_ready"}, bus.in_ready, 1);
            check({tag, "_after_valid"}, bus.span_valid, 0);
        end
    endtask

    initial begin
        bus.in_valid   = 1'b0;
        bus.span_ready = 1'b1;
        set_verts(0, 0, 0, 0, 0, 0);

        #2;
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_busy", bus.busy, 0);
        check("rst_span_valid", bus.span_valid, 0);
        check("rst_span_last", bus.span_last, 0);
        check("rst_span_y", bus.span_y, 0);
        check("rst_span_xl", bus.span_xl, 0);
        check("rst_span_xr", bus.span_xr, 0);
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("post_rst_valid", bus.span_valid, 0);

        load_tri(0);
        accept("flat", 1'b0);
        wait_valid("flat", 4);
        drain("flat", 1, -1, 1'b1);

        load_tri(1);
        accept("right", 1'b0);
        wait_valid("right", 68);
        drain("right", 5, -1, 1'b1);

        load_tri(2);
        accept("neg", 1'b0);
        wait_valid("neg", 100);
        drain("neg", 5, -1, 1'b1);

        load_tri(1);
        accept("bp", 1'b0);
        wait_valid("bp", 68);
        drain("bp", 5, 1, 1'b1);

        load_tri(1);
        accept("rmid", 1'b0);
        wait_valid("rmid", 68);
        drain("rmid", 2, -1, 1'b0);
        check_span("rmid_third", sb.pop_front());
        rst = 1'b1;
        #1;
        check("rmid_valid_now", bus.span_valid, 0);
        check("rmid_busy_now", bus.busy, 0);
        sb.delete();
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("rmid_after_valid", bus.span_valid, 0);
        check("rmid_after_ready", bus.in_ready, 1);
        load_tri(0);
        accept("rflat", 1'b0);
        wait_valid("rflat", 4);
        drain("rflat", 1, -1, 1'b1);

        load_tri(2);
        accept("held1", 1'b1);
        load_tri(1);
        repeat (5) tick();
        check("held1_div_in_ready", bus.in_ready, 0);
        wait_valid("held1", 95);
        drain("held1", 5, -1, 1'b1);
        tick();
        check("held2_accepted", bus.busy, 1);
        bus.in_valid = 1'b0;
        wait_valid("held2", 68);
        drain("held2", 5, -1, 1'b1);

        check("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
